cache_axi_rd_arbiter: RTL and testbench
=======================================

Name: cache_axi_rd_arbiter

Overview:
Shares one AXI4 read-address/read-data channel pair between the instruction cache and the data cache miss paths. Accepts single-word (uncached) and 4-word line-refill requests on the cache-side rd_req/rd_rdy/ret_valid interface. Issues them one at a time as AXI bursts and assembles the returned beats into a 128-bit line. Sits between the two caches and the CPU top-level AXI master port.

Parameters:
ID_IC, 4'd0, arid driven for icache-owned transactions
ID_DC, 4'd1, arid driven for dcache-owned transactions

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
ic_rd_req  in  1  icache read request, held until accepted
ic_rd_type  in  3  3'b010 word, 3'b100 line (4 words)
ic_rd_addr  in  32  request byte address (line-aligned for line type)
ic_rd_rdy  out  1  request accepted this cycle
ic_ret_valid  out  1  one-cycle pulse, ic_ret_data valid
ic_ret_data  out  128  word k at [32k+31:32k]; word request in [31:0]
dc_rd_req, dc_rd_type, dc_rd_addr, dc_rd_rdy, dc_ret_valid, dc_ret_data  same widths/meaning, dcache side
arid  out  4  owner ID
araddr  out  32  latched request address
arlen  out  8  0 for word, 3 for line
arsize  out  3  constant 3'b010
arburst  out  2  constant 2'b01 (INCR)
arvalid  out  1  address valid
arready  in  1  slave accepts address
rid  in  4  ignored (single outstanding)
rdata  in  32  beat data
rresp  in  2  ignored
rlast  in  1  last beat
rvalid  in  1  beat valid
rready  out  1  master ready for beat

Behaviour:
- Decided: reset resetn, synchronous, active-low; clock clk.
- State machine has four states: IDLE, AR, R and RET. One transaction is outstanding at a time.
- Reset: state=IDLE, last_grant=IC (so dcache wins the first tie). Buffer, counter, arvalid, rready, both rd_rdy and both ret_valid are 0. araddr/arlen/arid come from zeroed latches.
- IDLE arbitration:
  - If exactly one rd_req is high, that requester wins.
  - If both are high, the one not equal to last_grant wins (round-robin).
  - The winner's rd_rdy=1 combinationally in the same cycle. The loser's rd_rdy=0.
  - On acceptance: latch owner, addr and type; clear the 128-bit buffer and the 2-bit beat counter; set last_grant=owner; go to AR.
  - rd_rdy is never asserted outside IDLE.
- Latch encoding: rd_type 3'b100 gives arlen=3. Any other value is treated as a word request, arlen=0.
- AR:
  - arvalid=1 with stable araddr/arlen/arid (arid = ID_IC or ID_DC per owner).
  - On arvalid&&arready, go to R at the next cycle. arvalid drops the same edge.
  - Earliest arvalid is the cycle after acceptance.
- R:
  - rready=1.
  - Each rvalid beat writes rdata into buffer word [cnt], then cnt increments.
  - cnt saturates at 3. Beats beyond the 4th without rlast are dropped (the word-3 slot is not overwritten).
  - rvalid&&rlast goes to RET. An early rlast leaves the unwritten words zero.
- RET:
  - The owner's ret_valid=1 for exactly one cycle, with ret_data = buffer. The other requester's ret_valid=0.
  - ret_data is driven from the buffer at all times. It is only meaningful while ret_valid is high.
  - Next state is IDLE. A new request can be accepted in the cycle after RET.
- Minimum latency from acceptance to ret_valid: arready in cycle 1, first beat in cycle 2, giving ret_valid at cycle 3 (word) or cycle 6 (line, back-to-back beats).
- The arbiter keeps requesters blocked while a transaction is in flight. A request raised in AR/R/RET waits for IDLE.
- Reset mid-operation: any state returns to IDLE and all outputs clear. The AXI slave is reset by the same resetn.

Test Plan:
- Reset: hold resetn=0 3 cycles -> arvalid=0, rready=0, ic/dc_rd_rdy=0, ic/dc_ret_valid=0.
- icache line read:
  - Stimulus: ic_rd_req=1, type=3'b100, addr=0x1FC00040; arready immediate; beats 0x11,0x22,0x33,0x44, rlast on the 4th.
  - Response: ic_rd_rdy at cycle 0, then araddr=0x1FC00040, arlen=3, arid=0.
  - Response: ic_ret_valid one cycle with ic_ret_data=0x00000044_00000033_00000022_00000011.
- dcache uncached word:
  - Stimulus: dc_rd_req type=3'b010, addr=0xBFAF8004; arready delayed 5 cycles; one beat 0xDEADBEEF with rlast.
  - Response: arvalid is held the full 5 cycles; arlen=0, arid=1.
  - Response: dc_ret_data[31:0]=0xDEADBEEF, upper 96 bits 0.
- Simultaneous requests after reset:
  - Stimulus: both rd_req high, both held.
  - Response: dc granted first, then ic on the next IDLE; alternation continues for 4 transactions (dc,ic,dc,ic).
- rvalid gaps: line read with rvalid low 2 cycles between each beat -> buffer words in correct order, ret_valid only after rlast, rready held high throughout R.
- Reset mid-burst: assert resetn=0 after the 2nd beat -> next cycle state IDLE, rready=0, no ret_valid. A subsequent request completes normally.

Source files
------------

// File: rtl/cache_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_axi_rd_arbiter
// Brief    : Round-robin share of one AXI4 read channel pair between the
//            icache and dcache miss paths; assembles beats into a 128-bit line.
// Revision : 1.0 - initial release
// ============================================================================
module cache_axi_rd_arbiter #(
    parameter logic [3:0] ID_IC = 4'd0,
    parameter logic [3:0] ID_DC = 4'd1
) (
    input  logic         clk,
    input  logic         resetn,

    input  logic         ic_rd_req,
    input  logic [2:0]   ic_rd_type,
    input  logic [31:0]  ic_rd_addr,
    output logic         ic_rd_rdy,
    output logic         ic_ret_valid,
    output logic [127:0] ic_ret_data,

    input  logic         dc_rd_req,
    input  logic [2:0]   dc_rd_type,
    input  logic [31:0]  dc_rd_addr,
    output logic         dc_rd_rdy,
    output logic         dc_ret_valid,
    output logic [127:0] dc_ret_data,

    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,

    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);

    localparam logic [2:0] c_TYPE_LINE = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_RET  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_owner;        // 1 = dcache
    logic           r_last_grant;   // 1 = dcache
    logic           r_is_line;
    logic [31:0]    r_addr;
    logic [127:0]   r_buf;
    logic [1:0]     r_cnt;
    logic           r_full;
    logic           w_grant_ic;
    logic           w_grant_dc;
    logic           w_unused_ok;

    // Single outstanding transaction, so the returned ID and response carry no information.
    assign w_unused_ok = ^{rid, rresp};

    always_comb begin
        w_next     = r_state;
        w_grant_ic = 1'b0;
        w_grant_dc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ic_rd_req && (!dc_rd_req || r_last_grant)) begin
                    w_grant_ic = 1'b1;
                end else if (dc_rd_req) begin
                    w_grant_dc = 1'b1;
                end
                if (w_grant_ic || w_grant_dc) begin
                    w_next = S_AR;
                end
            end
            S_AR: begin
                if (arready) begin
                    w_next = S_R;
                end
            end
            S_R: begin
                if (rvalid && rlast) begin
                    w_next = S_RET;
                end
            end
            S_RET: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b0;
            r_is_line    <= 1'b0;
            r_addr       <= 32'd0;
            r_buf        <= 128'd0;
            r_cnt        <= 2'd0;
            r_full       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant_ic || w_grant_dc) begin
                r_owner      <= w_grant_dc;
                r_last_grant <= w_grant_dc;
                r_addr       <= w_grant_dc ? dc_rd_addr : ic_rd_addr;
                r_is_line    <= w_grant_dc ? (dc_rd_type == c_TYPE_LINE)
                                           : (ic_rd_type == c_TYPE_LINE);
                r_buf        <= 128'd0;
                r_cnt        <= 2'd0;
                r_full       <= 1'b0;
            end
            // Once word 3 is written, further beats are dropped until rlast.
            if (r_state == S_R && rvalid && !r_full) begin
                r_buf[{r_cnt, 5'b0} +: 32] <= rdata;
                if (r_cnt == 2'd3) begin
                    r_full <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 2'd1;
                end
            end
        end
    end

    assign ic_rd_rdy    = w_grant_ic;
    assign dc_rd_rdy    = w_grant_dc;
    assign ic_ret_valid = (r_state == S_RET) && !r_owner;
    assign dc_ret_valid = (r_state == S_RET) && r_owner;
    assign ic_ret_data  = r_buf;
    assign dc_ret_data  = r_buf;

    assign arid    = r_owner ? ID_DC : ID_IC;
    assign araddr  = r_addr;
    assign arlen   = r_is_line ? 8'd3 : 8'd0;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arvalid = (r_state == S_AR);
    assign rready  = (r_state == S_R);

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_axi_rd_arbiter
// Brief    : Directed self-checking bench for cache_axi_rd_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_axi_rd_arbiter;

    logic         clk = 1'b0;
    logic         resetn;
    logic         ic_rd_req, dc_rd_req;
    logic [2:0]   ic_rd_type, dc_rd_type;
    logic [31:0]  ic_rd_addr, dc_rd_addr;
    logic         ic_rd_rdy, dc_rd_rdy, ic_ret_valid, dc_ret_valid;
    logic [127:0] ic_ret_data, dc_ret_data;
    logic [3:0]   arid, rid;
    logic [31:0]  araddr, rdata;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst, rresp;
    logic         arvalid, arready, rlast, rvalid, rready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_axi_rd_arbiter #(.ID_IC(4'd0), .ID_DC(4'd1)) dut (
        .clk(clk), .resetn(resetn),
        .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
        .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_data(ic_ret_data),
        .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
        .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid), .dc_ret_data(dc_ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise one request for a cycle; reports the rd_rdy values seen in that cycle.
    task automatic issue(input bit is_dc, input logic [2:0] t, input logic [31:0] a,
                         output logic rdy_own, output logic rdy_other);
        if (is_dc) begin
            dc_rd_req = 1'b1; dc_rd_type = t; dc_rd_addr = a;
        end else begin
            ic_rd_req = 1'b1; ic_rd_type = t; ic_rd_addr = a;
        end
        #1;
        rdy_own   = is_dc ? dc_rd_rdy : ic_rd_rdy;
        rdy_other = is_dc ? ic_rd_rdy : dc_rd_rdy;
        tick();
        ic_rd_req = 1'b0;
        dc_rd_req = 1'b0;
    endtask

    // Hold arready low for 'delay' cycles then accept; counts cycles arvalid was high.
    task automatic ar_hs(input int delay, output int hi);
        hi = 0;
        repeat (delay) begin
            if (arvalid) hi++;
            tick();
        end
        arready = 1'b1;
        #1;
        if (arvalid) hi++;
        tick();
        arready = 1'b0;
    endtask

    // One beat after 'gap' idle cycles; reports whether rready stayed high and any ret_valid seen.
    task automatic beat(input logic [31:0] d, input bit last, input int gap,
                        output logic rr_ok, output logic ret_seen);
        rr_ok = 1'b1;
        ret_seen = 1'b0;
        repeat (gap) begin
            #1;
            rr_ok &= rready;
            ret_seen |= ic_ret_valid | dc_ret_valid;
            tick();
        end
        rvalid = 1'b1; rdata = d; rlast = last;
        #1;
        rr_ok &= rready;
        ret_seen |= ic_ret_valid | dc_ret_valid;
        tick();
        rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({arvalid, rready, ic_rd_rdy, dc_rd_rdy, ic_ret_valid, dc_ret_valid} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b need 000000",
                     {arvalid, rready, ic_rd_rdy, dc_rd_rdy, ic_ret_valid, dc_ret_valid});
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_ic_line();
        logic own, oth, rr, rs, rr_all, rs_any;
        int hi;
        issue(1'b0, 3'b100, 32'h1FC0_0040, own, oth);
        n_cmp++;
        if ({own, oth} !== 2'b10) begin
            n_err++; $display("FAIL ic_line_rdy: got %b need 10", {own, oth});
        end
        n_cmp++;
        if ({arvalid, araddr, arlen, arid, arsize, arburst} !== {1'b1, 32'h1FC0_0040, 8'd3, 4'd0, 3'b010, 2'b01}) begin
            n_err++;
            $display("FAIL ic_line_ar: got v=%b a=%h len=%0d id=%0d sz=%b bu=%b need v=1 a=1fc00040 len=3 id=0 sz=010 bu=01",
                     arvalid, araddr, arlen, arid, arsize, arburst);
        end
        ar_hs(0, hi);
        rr_all = 1'b1; rs_any = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            beat(32'h11 * k, k == 4, 0, rr, rs);
            rr_all &= rr;
            if (k < 4) rs_any |= rs | ic_ret_valid;
        end
        n_cmp++;
        if ({rr_all, rs_any} !== 2'b10) begin
            n_err++; $display("FAIL ic_line_rphase: got rready_ok/ret_early=%b need 10", {rr_all, rs_any});
        end
        n_cmp++;
        if ({ic_ret_valid, dc_ret_valid} !== 2'b10 ||
            ic_ret_data !== 128'h00000044_00000033_00000022_00000011) begin
            n_err++;
            $display("FAIL ic_line_ret: got v=%b%b d=%h need v=10 d=00000044000000330000002200000011",
                     ic_ret_valid, dc_ret_valid, ic_ret_data);
        end
        tick();
        n_cmp++;
        if (ic_ret_valid !== 1'b0) begin
            n_err++; $display("FAIL ic_line_ret_pulse: got %b need 0", ic_ret_valid);
        end
    endtask

    task automatic test_dc_word();
        logic own, oth, rr, rs;
        int hi;
        issue(1'b1, 3'b010, 32'hBFAF_8004, own, oth);
        n_cmp++;
        if ({own, oth, araddr, arlen, arid} !== {2'b10, 32'hBFAF_8004, 8'd0, 4'd1}) begin
            n_err++;
            $display("FAIL dc_word_ar: got rdy=%b%b a=%h len=%0d id=%0d need rdy=10 a=bfaf8004 len=0 id=1",
                     own, oth, araddr, arlen, arid);
        end
        ar_hs(5, hi);
        n_cmp++;
        if (hi !== 6 || arvalid !== 1'b0) begin
            n_err++; $display("FAIL dc_word_arvalid_hold: got %0d cycles (now %b) need 6 (now 0)", hi, arvalid);
        end
        beat(32'hDEAD_BEEF, 1'b1, 0, rr, rs);
        n_cmp++;
        if ({ic_ret_valid, dc_ret_valid} !== 2'b01 || dc_ret_data !== {96'd0, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL dc_word_ret: got v=%b%b d=%h need v=01 d=000000000000000000000000deadbeef",
                     ic_ret_valid, dc_ret_valid, dc_ret_data);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic rr, rs;
        int hi;
        logic exp_dc;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        ic_rd_req = 1'b1; ic_rd_type = 3'b010; ic_rd_addr = 32'h0000_0100;
        dc_rd_req = 1'b1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_0200;
        for (int k = 0; k < 4; k++) begin
            exp_dc = (k % 2 == 0);
            #1;
            n_cmp++;
            if ({dc_rd_rdy, ic_rd_rdy} !== {exp_dc, !exp_dc}) begin
                n_err++; $display("FAIL rr_grant%0d: got dc/ic=%b%b need %b%b", k, dc_rd_rdy, ic_rd_rdy, exp_dc, !exp_dc);
            end
            tick();
            n_cmp++;
            if ({arid, araddr, dc_rd_rdy, ic_rd_rdy} !==
                {(exp_dc ? 4'd1 : 4'd0), (exp_dc ? 32'h200 : 32'h100), 2'b00}) begin
                n_err++; $display("FAIL rr_ar%0d: got id=%0d a=%h rdy=%b%b need id=%0d blocked", k, arid, araddr,
                                  dc_rd_rdy, ic_rd_rdy, exp_dc);
            end
            ar_hs(0, hi);
            beat(32'hA000_0000 + k, 1'b1, 0, rr, rs);
            n_cmp++;
            if ({dc_ret_valid, ic_ret_valid} !== {exp_dc, !exp_dc} || ic_ret_data[31:0] !== 32'hA000_0000 + k) begin
                n_err++; $display("FAIL rr_ret%0d: got dc/ic=%b%b d=%h need %b%b d=%h", k, dc_ret_valid, ic_ret_valid,
                                  ic_ret_data[31:0], exp_dc, !exp_dc, 32'hA000_0000 + k);
            end
            tick();
        end
        ic_rd_req = 1'b0;
        dc_rd_req = 1'b0;
    endtask

    task automatic test_rvalid_gaps();
        logic own, oth, rr, rs, rr_all, rs_any;
        int hi;
        issue(1'b1, 3'b100, 32'h0000_1230, own, oth);
        ar_hs(0, hi);
        rr_all = 1'b1; rs_any = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            beat(32'hA0 + k, k == 4, 2, rr, rs);
            rr_all &= rr;
            rs_any |= rs;
        end
        n_cmp++;
        if ({rr_all, rs_any} !== 2'b10) begin
            n_err++; $display("FAIL gaps_rphase: got rready_ok/ret_early=%b need 10", {rr_all, rs_any});
        end
        n_cmp++;
        if (dc_ret_valid !== 1'b1 || dc_ret_data !== 128'h000000A4_000000A3_000000A2_000000A1) begin
            n_err++; $display("FAIL gaps_ret: got v=%b d=%h need v=1 d=000000a4000000a3000000a2000000a1",
                              dc_ret_valid, dc_ret_data);
        end
        tick();
    endtask

    task automatic test_overrun_early();
        logic own, oth, rr, rs;
        int hi;
        issue(1'b0, 3'b100, 32'h0000_2000, own, oth);
        ar_hs(0, hi);
        for (int k = 1; k <= 5; k++) beat(32'h1 * k, k == 5, 0, rr, rs);
        n_cmp++;
        if (ic_ret_valid !== 1'b1 || ic_ret_data !== 128'h00000004_00000003_00000002_00000001) begin
            n_err++; $display("FAIL overrun_ret: got v=%b d=%h need v=1 d=00000004000000030000000200000001",
                              ic_ret_valid, ic_ret_data);
        end
        tick();
        issue(1'b1, 3'b100, 32'h0000_3000, own, oth);
        ar_hs(0, hi);
        beat(32'h77, 1'b0, 0, rr, rs);
        beat(32'h88, 1'b1, 0, rr, rs);
        n_cmp++;
        if (dc_ret_valid !== 1'b1 || dc_ret_data !== {64'd0, 32'h88, 32'h77}) begin
            n_err++; $display("FAIL early_rlast_ret: got v=%b d=%h need v=1 d=00000000000000000000008800000077",
                              dc_ret_valid, dc_ret_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        logic own, oth, rr, rs;
        int hi;
        issue(1'b0, 3'b100, 32'h0000_4000, own, oth);
        ar_hs(0, hi);
        beat(32'h1, 1'b0, 0, rr, rs);
        beat(32'h2, 1'b0, 0, rr, rs);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        n_cmp++;
        if ({rready, arvalid, ic_ret_valid, dc_ret_valid} !== 4'b0) begin
            n_err++; $display("FAIL midreset_clear: got rr/arv/ret=%b need 0000",
                              {rready, arvalid, ic_ret_valid, dc_ret_valid});
        end
        issue(1'b1, 3'b010, 32'h0000_5004, own, oth);
        n_cmp++;
        if ({own, arvalid, arid} !== {2'b11, 4'd1}) begin
            n_err++; $display("FAIL midreset_accept: got rdy=%b arv=%b id=%0d need 1 1 1", own, arvalid, arid);
        end
        ar_hs(0, hi);
        beat(32'hCAFE_F00D, 1'b1, 0, rr, rs);
        n_cmp++;
        if (dc_ret_valid !== 1'b1 || dc_ret_data !== {96'd0, 32'hCAFE_F00D}) begin
            n_err++; $display("FAIL midreset_ret: got v=%b d=%h need v=1 d=...cafef00d", dc_ret_valid, dc_ret_data);
        end
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        ic_rd_req = 1'b0; ic_rd_type = 3'b0; ic_rd_addr = 32'd0;
        dc_rd_req = 1'b0; dc_rd_type = 3'b0; dc_rd_addr = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0; rvalid = 1'b0;
        test_reset();
        test_ic_line();
        test_dc_word();
        test_round_robin();
        test_rvalid_gaps();
        test_overrun_early();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
